oric_tape_decoder: RTL and testbench
====================================

Name: oric_tape_decoder

Overview:
- Receive end of the Oric cassette interface: demodulates the pulse train the core drives on K7_TAPEOUT back into framed bytes.
- Frame format is Oric fast mode: start bit, 8 data bits LSB first, odd parity, stop bit(s).
- Bytes go to a downstream consumer, such as a tape-capture buffer or loopback checker, over a one-entry valid/ready holding register.
- Sits in the clk_sys domain beside the oricatmos instance.

Parameters:
- US_DIV, 24: clk_sys cycles per microsecond tick.
- MIN_US, 100: periods shorter than this are glitches.
- THRESH_US, 312: period < THRESH_US is bit 1; period ≥ THRESH_US is bit 0.
- MAX_US, 600: period at or above this is loss of carrier.
- SYNC_ONES, 8: consecutive 1 bits required to arm.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tape_out  in  1  cassette output level from core; treated as asynchronous
- enable  in  1  0 forces IDLE and clears counters
- byte_data  out  8  received byte
- byte_parity_err  out  1  parity failed for byte_data; qualified by byte_valid
- byte_valid  out  1  holding register full
- byte_ready  in  1  consumer accepts when byte_valid & byte_ready
- overrun  out  1  one-cycle pulse: completed byte dropped, holding register full
- frame_err  out  1  one-cycle pulse: stop bit read as 0
- carrier  out  1  high in ARMED/DATA/PARITY/STOP

Behaviour:
- Reset and enable:
  - Reset: all outputs 0, state IDLE, counters 0.
  - Reset or enable=0 mid-byte: partial byte discarded. The holding register is also cleared by reset, but not by enable=0.
- Input conditioning: 2-FF synchronizer, then a delay FF. A rising edge is flagged 3 clk_sys after the tape_out rise (±1 clk).
- Prescaler and period counter:
  - Prescaler counts 0..US_DIV-1 and emits us_tick.
  - 10-bit period counter increments on us_tick and saturates at 1023.
- On a flagged edge with period p:
  - p < MIN_US: edge ignored; the counter keeps running.
  - Otherwise: counter cleared, bit = (p < THRESH_US).
  - p ≥ MAX_US: treated as timeout, not as a bit.
- Timeout: counter reaching MAX_US with no edge, or an edge with p ≥ MAX_US. State goes to IDLE, ones count cleared, no pulses.
- States:
  - IDLE: count consecutive 1 bits; a 0 clears the count. Count reaching SYNC_ONES goes to ARMED.
  - ARMED: a 1 stays; a 0 (start bit) goes to DATA with bit index 0.
  - DATA: shift bit into bit[index]; index 7 goes to PARITY.
  - PARITY: capture bit; parity_ok = XOR(data, parity) == 1. Go to STOP.
  - STOP, bit 1: byte complete, go to ARMED.
  - STOP, bit 0: frame_err pulse, byte dropped, go to IDLE.
  - Extra stop/idle 1s are absorbed in ARMED.
- Delivery:
  - Byte completes on the classifying edge at cycle E.
  - If the holding register is empty, or byte_ready=1 at E: load byte_data/byte_parity_err and assert byte_valid from E+1.
  - Otherwise: keep the old byte, pulse overrun at E+1.
  - byte_valid falls the cycle after a handshake unless a new byte loads in that same cycle.
- Parity error: the byte is still delivered, with byte_parity_err=1.

Test Plan:
- Clean byte (US_DIV=24; 1 = 208 µs = 4992 clk period, 0 = 416 µs = 9984 clk):
  - Stimulus: 10 ones, then start 0, 0x16 LSB first (0,1,1,0,1,0,0,0), parity 0, stop 1, byte_ready=1.
  - Response: byte_valid 1 cycle with byte_data=0x16, byte_parity_err=0; carrier=1 from the 8th one.
- Parity error:
  - Stimulus: same byte with parity bit 1.
  - Response: byte_data=0x16, byte_parity_err=1.
- Overrun:
  - Stimulus: byte_ready=0, send 0x16 then 0xA5 (parity 1).
  - Response: byte_data stays 0x16; overrun pulses once at completion of 0xA5.
  - Stimulus: raise byte_ready.
  - Response: byte_valid drops next cycle.
- Glitch and timeout:
  - Stimulus: 40 µs pulse mid-DATA.
  - Response: ignored, byte correct.
  - Stimulus: 700 µs gap mid-DATA.
  - Response: carrier=0, no byte; the next byte needs 8 ones before it is received.
- Framing error:
  - Stimulus: stop bit sent as 0 (416 µs).
  - Response: frame_err pulse, no byte_valid, carrier=0.
- Reset:
  - Stimulus: assert reset_n=0 asynchronously during DATA with byte_valid=1.
  - Response: all outputs 0 immediately.
  - Stimulus: release reset and send a clean byte.
  - Response: byte received normally.

Source files
------------

// File: rtl/oric_tape_decoder.sv
// oric_tape_decoder: receive side of the Oric cassette interface.
// Measures the time between rising edges of the core's K7_TAPEOUT level,
// turns each period into a bit (short = 1, long = 0), and frames fast-mode
// bytes: 8+ sync ones, start 0, 8 data bits LSB first, odd parity, stop 1.
// Completed bytes sit in a one-entry valid/ready holding register.
//
// Ports:
//   clk_sys         system clock
//   reset_n         asynchronous active-low reset
//   tape_out        cassette level from the core (asynchronous)
//   enable          0 forces IDLE and clears the timing counters
//   byte_data       received byte              (qualified by byte_valid)
//   byte_parity_err parity failed for byte_data (qualified by byte_valid)
//   byte_valid      holding register full
//   byte_ready      consumer accepts on byte_valid & byte_ready
//   overrun         1-cycle pulse: completed byte dropped, register full
//   frame_err       1-cycle pulse: stop bit read as 0
//   carrier         high while ARMED / DATA / PARITY / STOP
module oric_tape_decoder #(
  parameter int US_DIV    = 24,
  parameter int MIN_US    = 100,
  parameter int THRESH_US = 312,
  parameter int MAX_US    = 600,
  parameter int SYNC_ONES = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tape_out,
  input  logic       enable,
  output logic [7:0] byte_data,
  output logic       byte_parity_err,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       carrier
);

  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int OW = $clog2(SYNC_ONES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(US_DIV - 1);
  localparam logic [9:0]    MIN_P      = 10'(MIN_US);
  localparam logic [9:0]    THRESH_P   = 10'(THRESH_US);
  localparam logic [9:0]    MAX_P      = 10'(MAX_US);
  localparam logic [OW-1:0] ONES_LAST  = OW'(SYNC_ONES - 1);

  typedef enum logic [2:0] {IDLE, ARMED, DATA, PARITY, STOP} state_t;

  logic [1:0]    sync_q;
  logic          dly_q;
  logic [PW-1:0] presc_q;
  logic [9:0]    per_q;
  state_t        state_q;
  logic [OW-1:0] ones_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [7:0]    data_q;
  logic          perr_q, valid_q, overrun_q, ferr_q, carrier_q;

  logic rise, us_tick, edge_ok, bit_ev, bit1, tmo;

  always_comb begin
    rise    = sync_q[1] & ~dly_q;
    us_tick = (presc_q == PRESC_LAST);
    // Edges closer than MIN_US to the last accepted edge are glitches and
    // leave the period counter running.
    edge_ok = rise && (per_q >= MIN_P);
    bit_ev  = edge_ok && (per_q < MAX_P);
    bit1    = (per_q < THRESH_P);
    // Loss of carrier: a too-long period, or the counter reaching MAX_US
    // with no accepted edge this cycle.
    tmo     = (edge_ok && (per_q >= MAX_P)) ||
              (!edge_ok && us_tick && (per_q == MAX_P - 10'd1));
  end

  // Synchronizer, edge detect delay, microsecond prescaler, period counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      presc_q <= '0;
      per_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], tape_out};
      dly_q  <= sync_q[1];
      if (!enable || edge_ok) begin
        presc_q <= '0;
        per_q   <= '0;
      end else if (us_tick) begin
        presc_q <= '0;
        if (per_q != 10'h3FF) per_q <= per_q + 10'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  // Framing FSM with registered outputs and holding register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      carrier_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      // A load in STOP below overrides this drop.
      if (valid_q && byte_ready) valid_q <= 1'b0;
      if (!enable || tmo) begin
        state_q   <= IDLE;
        ones_q    <= '0;
        idx_q     <= '0;
        carrier_q <= 1'b0;
      end else if (bit_ev) begin
        case (state_q)
          IDLE: begin
            if (!bit1) begin
              ones_q <= '0;
            end else if (ones_q == ONES_LAST) begin
              ones_q    <= '0;
              state_q   <= ARMED;
              carrier_q <= 1'b1;
            end else begin
              ones_q <= ones_q + OW'(1);
            end
          end
          ARMED: begin
            if (!bit1) begin
              state_q <= DATA;
              idx_q   <= '0;
            end
          end
          DATA: begin
            shift_q[idx_q] <= bit1;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bit1;
            state_q <= STOP;
          end
          STOP: begin
            if (bit1) begin
              state_q <= ARMED;
              if (!valid_q || byte_ready) begin
                data_q  <= shift_q;
                perr_q  <= ~(^shift_q ^ par_q);
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              ferr_q    <= 1'b1;
              state_q   <= IDLE;
              carrier_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign byte_data       = data_q;
  assign byte_parity_err = perr_q;
  assign byte_valid      = valid_q;
  assign overrun         = overrun_q;
  assign frame_err       = ferr_q;
  assign carrier         = carrier_q;

endmodule

// File: tb/tb_oric_tape_decoder.sv
// tb_oric_tape_decoder: scoreboard bench for oric_tape_decoder.
// US_DIV=1 keeps the run short; all bit timings are still expressed in us.
module tb_oric_tape_decoder;
  localparam int US = 1;

  logic       clk_sys = 1'b0, reset_n = 1'b0, tape_out = 1'b0;
  logic       enable = 1'b1, byte_ready = 1'b1;
  logic [7:0] byte_data;
  logic       byte_parity_err, byte_valid, overrun, frame_err, carrier;

  oric_tape_decoder #(.US_DIV(US)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .tape_out(tape_out),
    .enable(enable), .byte_data(byte_data),
    .byte_parity_err(byte_parity_err), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .overrun(overrun), .frame_err(frame_err),
    .carrier(carrier)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0, n_fail = 0, n_ovr = 0, n_ferr = 0, n_bytes = 0;
  logic [8:0] exp_q[$];  // {parity_err, data}

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output side: pop the scoreboard on every handshake, count pulses.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (overrun) n_ovr++;
      if (frame_err) n_ferr++;
      if (byte_valid && byte_ready) begin
        logic [8:0] e;
        n_bytes++;
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("byte_data", byte_data, e[7:0]);
          chk("byte_parity_err", byte_parity_err, e[8]);
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Rising edge, 20 us high, low for the rest of the period. With gl set,
  // a 40 us glitch pulse rises 50 us after the edge.
  task automatic pw(input int us, input bit gl = 1'b0);
    tape_out = 1'b1; wclk(20 * US); tape_out = 1'b0;
    if (gl) begin
      wclk(30 * US); tape_out = 1'b1; wclk(40 * US); tape_out = 1'b0;
      wclk((us - 90) * US);
    end else begin
      wclk((us - 20) * US);
    end
  endtask

  // Periods for `ones` sync ones, then frame bits [0..cut-1]. Each period is
  // classified by the following edge, so the caller supplies the next edge.
  task automatic send_frame(input int ones, input logic [7:0] d, input bit par,
                            input bit stp, input int gl = -1, input int cut = 11,
                            input bit push = 1'b1, input bit chk_car = 1'b0);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < ones; i++) begin
      pw(208);
      // The first edge follows silence and only starts timing.
      if (chk_car && i == 7) chk("carrier_7ones", carrier, 0);
      if (chk_car && i == 8) chk("carrier_8ones", carrier, 1);
    end
    if (push && cut == 11 && stp) exp_q.push_back({~(^d ^ par), d});
    for (int i = 0; i < cut; i++) pw(bits[i] ? 208 : 416, i == gl);
  endtask

  task automatic close_line();
    pw(700);
  endtask

  int b0, o0, f0;

  initial begin
    wclk(3);
    chk("reset_outs", {byte_data, byte_parity_err, byte_valid, overrun, frame_err, carrier}, 0);
    reset_n = 1'b1;
    wclk(700 * US);

    // Clean byte
    b0 = n_bytes;
    send_frame(10, 8'h16, 1'b0, 1'b1, -1, 11, 1'b1, 1'b1);
    close_line();
    chk("clean_bytes", n_bytes - b0, 1);
    chk("valid_one_cycle", byte_valid, 0);
    chk("q_empty_clean", exp_q.size(), 0);

    // Parity error
    send_frame(8, 8'h16, 1'b1, 1'b1);
    close_line();
    chk("q_empty_par", exp_q.size(), 0);

    // Overrun: second byte dropped while first is held
    byte_ready = 1'b0;
    o0 = n_ovr;
    send_frame(8, 8'h16, 1'b0, 1'b1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, -1, 11, 1'b0);
    close_line();
    chk("overrun_pulses", n_ovr - o0, 1);
    chk("held_data", byte_data, 8'h16);
    chk("held_valid", byte_valid, 1);
    byte_ready = 1'b1;
    wclk(1);
    chk("valid_drop", byte_valid, 0);
    chk("q_empty_ovr", exp_q.size(), 0);

    // Glitch mid-DATA
    send_frame(8, 8'h16, 1'b0, 1'b1, 3);
    close_line();
    chk("q_empty_glitch", exp_q.size(), 0);

    // Timeout mid-DATA, then 7 ones are not enough, then 10 are
    b0 = n_bytes;
    send_frame(8, 8'h3C, 1'b1, 1'b1, -1, 5);
    pw(700);
    chk("carrier_timeout", carrier, 0);
    send_frame(7, 8'h16, 1'b0, 1'b1, -1, 11, 1'b0);
    close_line();
    chk("no_byte_7ones", n_bytes - b0, 0);
    send_frame(10, 8'h3C, 1'b1, 1'b1);
    close_line();
    chk("byte_after_tmo", n_bytes - b0, 1);
    chk("q_empty_tmo", exp_q.size(), 0);

    // Framing error
    b0 = n_bytes; f0 = n_ferr;
    send_frame(8, 8'h16, 1'b0, 1'b0);
    tape_out = 1'b1; wclk(20 * US);
    chk("carrier_ferr", carrier, 0);
    chk("valid_ferr", byte_valid, 0);
    tape_out = 1'b0; wclk(680 * US);
    chk("ferr_pulses", n_ferr - f0, 1);
    chk("no_byte_ferr", n_bytes - b0, 0);

    // enable=0 drops carrier mid-byte
    send_frame(8, 8'h16, 1'b0, 1'b1, -1, 3);
    chk("carrier_data", carrier, 1);
    enable = 1'b0; wclk(2);
    chk("carrier_en0", carrier, 0);
    enable = 1'b1; wclk(700 * US);

    // Async reset during DATA with a byte held
    byte_ready = 1'b0;
    send_frame(8, 8'h16, 1'b0, 1'b1);
    send_frame(1, 8'hA5, 1'b1, 1'b1, -1, 5);
    chk("pre_rst_valid", byte_valid, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outs", {byte_data, byte_parity_err, byte_valid, overrun, frame_err, carrier}, 0);
    exp_q.delete();
    wclk(3);
    reset_n = 1'b1; byte_ready = 1'b1;
    wclk(700 * US);
    b0 = n_bytes;
    send_frame(10, 8'h3C, 1'b1, 1'b1);
    close_line();
    chk("byte_after_rst", n_bytes - b0, 1);
    chk("q_empty_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
